// File: rtl/monitor_pkg.sv
// monitor_pkg: shared definitions for the monitor_media block.
//   state_t : handshake FSM encoding (S_IDLE=0, S_UPD=1, S_WAIT=2)
//   CNT_W   : width of the accepted-sample counter
//   DEB_W   : width of the alarm debounce counters
package monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UPD  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam int CNT_W = 16;
  localparam int DEB_W = 4;

endpackage

// File: rtl/monitor_media_isteresi_allarme.sv
// isteresi_allarme: debounced over-voltage alarm with hysteresis.
//   clock, reset : clock and synchronous active-high reset
//   en           : one-cycle strobe, high while the top FSM is in S_UPD
//   clr          : statistics clear (also clears the alarm when
//                  MONITOR_STICKY_ALARM_EN is defined)
//   sample       : the sample being applied during en
//   alarm        : registered alarm output
// Optional feature: MONITOR_STICKY_ALARM_EN makes the alarm latch until
// reset or clr; the low debounce counter keeps running but never clears it.
module isteresi_allarme
  import monitor_pkg::*;
#(
  parameter int N     = 8,
  parameter int TH_HI = 200,
  parameter int TH_LO = 150,
  parameter int DEB   = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] sample,
  output logic         alarm
);

  localparam logic [DEB_W-1:0] DEB_V = DEB_W'(DEB);
  localparam logic [N-1:0]     HI_V  = N'(TH_HI);
  localparam logic [N-1:0]     LO_V  = N'(TH_LO);

  logic [DEB_W-1:0] hi_q, hi_d, hi_b;
  logic [DEB_W-1:0] lo_q, lo_d, lo_b;
  logic             alarm_q, alarm_d, alarm_b;

  always_comb begin
    // Base values: what the sample is applied on top of this cycle.
`ifdef MONITOR_STICKY_ALARM_EN
    hi_b    = clr ? '0   : hi_q;
    lo_b    = clr ? '0   : lo_q;
    alarm_b = clr ? 1'b0 : alarm_q;
`else
    hi_b    = hi_q;
    lo_b    = lo_q;
    alarm_b = alarm_q;
`endif
    hi_d    = hi_b;
    lo_d    = lo_b;
    alarm_d = alarm_b;
    if (en) begin
      // Thresholds are strict: samples equal to TH_HI or TH_LO reset both runs.
      if (sample > HI_V) begin
        hi_d = (hi_b >= DEB_V) ? DEB_V : hi_b + DEB_W'(1);
        lo_d = '0;
      end else if (sample < LO_V) begin
        lo_d = (lo_b >= DEB_V) ? DEB_V : lo_b + DEB_W'(1);
        hi_d = '0;
      end else begin
        hi_d = '0;
        lo_d = '0;
      end
      if (!alarm_b && hi_d == DEB_V) begin
        alarm_d = 1'b1;
      end
`ifndef MONITOR_STICKY_ALARM_EN
      else if (alarm_b && lo_d == DEB_V) begin
        alarm_d = 1'b0;
      end
`endif
    end
  end

`ifndef MONITOR_STICKY_ALARM_EN
  // clr has no effect on the alarm in the hysteresis build.
  logic unused_clr;
  assign unused_clr = clr;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      alarm_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;

endmodule

// File: rtl/monitor_media.sv
// monitor_media: consumer of the voltage averager; keeps last/min/max/count
// statistics and a debounced over-voltage alarm.
//   clock, reset : clock and synchronous active-high reset
//   dav_, avg    : producer data valid (active low) and sample
//   rfd          : ready for data to the producer (active high)
//   clr          : synchronous clear of vmin/vmax/cnt
//   last, vmin, vmax, cnt, alarm : registered statistics and alarm
//   dbg_state    : current FSM state, for observation only
// Handshake: a sample is taken on the first rising edge where rfd=1 and
// dav_=0; rfd then stays low until an edge sees dav_=1 again, so one
// dav_ low period always yields exactly one sample.
// Optional feature: MONITOR_STICKY_ALARM_EN (see isteresi_allarme).
module monitor_media
  import monitor_pkg::*;
#(
  parameter int N     = 8,
  parameter int TH_HI = 200,
  parameter int TH_LO = 150,
  parameter int DEB   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dav_,
  input  logic [N-1:0]     avg,
  output logic             rfd,
  input  logic             clr,
  output logic [N-1:0]     last,
  output logic [N-1:0]     vmin,
  output logic [N-1:0]     vmax,
  output logic [CNT_W-1:0] cnt,
  output logic             alarm,
  output logic [1:0]       dbg_state
);

  state_t           state_q;
  logic             rfd_q;
  logic [N-1:0]     last_q, vmin_q, vmax_q, vmin_d, vmax_d, vmin_b, vmax_b;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_b;
  logic             upd;

  assign upd = (state_q == S_UPD);

  // clr reinitialises the stats first; a sample in S_UPD is then applied
  // on top, so a coincident clr leaves exactly that one sample counted.
  always_comb begin
    vmin_b = clr ? '1 : vmin_q;
    vmax_b = clr ? '0 : vmax_q;
    cnt_b  = clr ? '0 : cnt_q;
    vmin_d = vmin_b;
    vmax_d = vmax_b;
    cnt_d  = cnt_b;
    if (upd) begin
      vmin_d = (last_q < vmin_b) ? last_q : vmin_b;
      vmax_d = (last_q > vmax_b) ? last_q : vmax_b;
      cnt_d  = (cnt_b == '1) ? cnt_b : cnt_b + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      rfd_q   <= 1'b1;
      last_q  <= '0;
      vmin_q  <= '1;
      vmax_q  <= '0;
      cnt_q   <= '0;
    end else begin
      vmin_q <= vmin_d;
      vmax_q <= vmax_d;
      cnt_q  <= cnt_d;
      case (state_q)
        S_IDLE: begin
          if (!dav_) begin
            last_q  <= avg;
            rfd_q   <= 1'b0;
            state_q <= S_UPD;
          end
        end
        S_UPD: begin
          if (dav_) begin
            rfd_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dav_) begin
            rfd_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          rfd_q   <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  isteresi_allarme #(
    .N     (N),
    .TH_HI (TH_HI),
    .TH_LO (TH_LO),
    .DEB   (DEB)
  ) u_isteresi_allarme (
    .clock  (clock),
    .reset  (reset),
    .en     (upd),
    .clr    (clr),
    .sample (last_q),
    .alarm  (alarm)
  );

  assign rfd       = rfd_q;
  assign last      = last_q;
  assign vmin      = vmin_q;
  assign vmax      = vmax_q;
  assign cnt       = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_monitor_media.sv
// tb_monitor_media: directed bench for monitor_media. Inputs change 1 time
// unit after a rising edge and outputs are checked at the same point.
module tb_monitor_media;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dav_  = 1'b1;
  logic [7:0]  avg   = '0;
  logic        clr   = 1'b0;
  logic        rfd;
  logic [7:0]  last, vmin, vmax;
  logic [15:0] cnt;
  logic        alarm;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic alarm_at_cap;

`ifdef MONITOR_STICKY_ALARM_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  monitor_media dut (
    .clock     (clock),
    .reset     (reset),
    .dav_      (dav_),
    .avg       (avg),
    .rfd       (rfd),
    .clr       (clr),
    .last      (last),
    .vmin      (vmin),
    .vmax      (vmax),
    .cnt       (cnt),
    .alarm     (alarm),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full handshake: dav_ low for 'hold' edges, then high for one edge.
  task automatic send(input logic [7:0] v, input int hold);
    avg  = v;
    dav_ = 1'b0;
    tick();
    chk("rfd_capture", 32'(rfd), 32'd0);
    alarm_at_cap = alarm;
    for (int i = 1; i < hold; i++) begin
      tick();
      chk("rfd_hold", 32'(rfd), 32'd0);
    end
    dav_ = 1'b1;
    tick();
    chk("rfd_return", 32'(rfd), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rfd"},   32'(rfd),       32'd1);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    chk({tag, "_last"},  32'(last),      32'd0);
    chk({tag, "_vmin"},  32'(vmin),      32'hFF);
    chk({tag, "_vmax"},  32'(vmax),      32'd0);
    chk({tag, "_cnt"},   32'(cnt),       32'd0);
    chk({tag, "_alarm"}, 32'(alarm),     32'd0);
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_vals("reset");

    // Basic statistics
    send(8'd100, 1);
    send(8'd40, 1);
    send(8'd220, 1);
    chk("basic_last", 32'(last), 32'd220);
    chk("basic_vmin", 32'(vmin), 32'd40);
    chk("basic_vmax", 32'(vmax), 32'd220);
    chk("basic_cnt",  32'(cnt),  32'd3);
    chk("basic_alarm", 32'(alarm), 32'd0);

    // Broken high run: 180 resets the run left by 220, 200 breaks it again
    send(8'd180, 1);
    send(8'd201, 1);
    send(8'd201, 1);
    send(8'd200, 1);
    send(8'd201, 1);
    chk("broken_run_alarm", 32'(alarm), 32'd0);

    // Three consecutive highs set the alarm one cycle after the third capture
    send(8'd180, 1);
    send(8'd201, 1);
    send(8'd201, 1);
    chk("two_hi_alarm", 32'(alarm), 32'd0);
    send(8'd201, 1);
    chk("set_alarm_at_capture", 32'(alarm_at_cap), 32'd0);
    chk("set_alarm_after", 32'(alarm), 32'd1);
    chk("set_cnt", 32'(cnt), 32'd12);

    // Hysteresis clear: 150 breaks the low run
    send(8'd149, 1);
    send(8'd149, 1);
    send(8'd150, 1);
    send(8'd149, 1);
    send(8'd149, 1);
    chk("lo_run2_alarm", 32'(alarm), 32'd1);
    send(8'd149, 1);
    chk("lo_run3_alarm", 32'(alarm), 32'(STICKY));
    chk("lo_vmin", 32'(vmin), 32'd40);
    chk("lo_cnt", 32'(cnt), 32'd18);

    // clr in S_IDLE
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_idle_vmin", 32'(vmin), 32'hFF);
    chk("clr_idle_vmax", 32'(vmax), 32'd0);
    chk("clr_idle_cnt",  32'(cnt),  32'd0);
    chk("clr_idle_last", 32'(last), 32'd149);
    chk("clr_idle_alarm", 32'(alarm), 32'd0);

    // dav_ held low for 10 cycles yields a single sample
    send(8'd123, 10);
    chk("long_cnt",  32'(cnt),  32'd1);
    chk("long_last", 32'(last), 32'd123);
    tick();
    chk("long_idle_cnt", 32'(cnt), 32'd1);

    // dav_ low for one cycle: S_UPD straight back to S_IDLE
    avg  = 8'd90;
    dav_ = 1'b0;
    tick();
    chk("short_state_upd", 32'(dbg_state), 32'd1);
    chk("short_rfd_low", 32'(rfd), 32'd0);
    dav_ = 1'b1;
    tick();
    chk("short_state_idle", 32'(dbg_state), 32'd0);
    chk("short_rfd_high", 32'(rfd), 32'd1);
    chk("short_cnt", 32'(cnt), 32'd2);
    chk("short_vmin", 32'(vmin), 32'd90);

    // clr coinciding with S_UPD for sample 77
    avg  = 8'd77;
    dav_ = 1'b0;
    tick();
    clr  = 1'b1;
    dav_ = 1'b1;
    tick();
    clr  = 1'b0;
    chk("clr_upd_cnt",  32'(cnt),  32'd1);
    chk("clr_upd_vmin", 32'(vmin), 32'd77);
    chk("clr_upd_vmax", 32'(vmax), 32'd77);
    chk("clr_upd_last", 32'(last), 32'd77);

    // Reset while in S_WAIT with dav_ still low
    avg  = 8'd55;
    dav_ = 1'b0;
    tick();
    tick();
    chk("wait_state", 32'(dbg_state), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dav_  = 1'b1;
    check_reset_vals("wait_reset");

    // Counter saturation from a preloaded value
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    tick();
    chk("preload_cnt", 32'(cnt), 32'hFFFE);
    send(8'd10, 1);
    chk("sat1_cnt", 32'(cnt), 32'hFFFF);
    send(8'd20, 1);
    chk("sat2_cnt", 32'(cnt), 32'hFFFF);
    chk("sat_vmax", 32'(vmax), 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
